// File: rtl/blink_pkg.sv
// Shared mode/state encodings for the multi-digit anode blinker.
package blink_pkg;

   typedef enum logic [1:0] {
      PASS       = 2'd0,
      BLINK_SYM  = 2'd1,
      BLINK_ASYM = 2'd2,
      BLANK      = 2'd3
   } blink_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      HIDE = 2'd2
   } blink_state_t;

   function automatic logic is_blink(input logic [1:0] m);
      return (m == BLINK_SYM) || (m == BLINK_ASYM);
   endfunction

endpackage

// File: rtl/blink_phase_gen.sv
// Visible/hidden cadence generator: phase FSM plus tick counter with live limits.
module blink_phase_gen
   import blink_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             restart,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] on_ticks,
   input  logic [CNT_W-1:0] off_ticks,
   output logic             hide,
   output logic             visible
);

   blink_state_t     state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] eff_on, eff_off;
   logic [CNT_W:0]   cnt_inc;
   logic             blink_now;

   assign blink_now = is_blink(mode);
   assign eff_on    = (on_ticks == '0) ? CNT_W'(1) : on_ticks;
   assign eff_off   = (mode == BLINK_ASYM) ? ((off_ticks == '0) ? CNT_W'(1) : off_ticks)
                                           : eff_on;
   // One extra bit so the compare never sees a wrapped count.
   assign cnt_inc   = {1'b0, cnt} + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!blink_now) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = SHOW;
               cnt_nxt   = '0;
            end
            SHOW: begin
               if (restart) begin
                  cnt_nxt = '0;
               end else if (tick) begin
                  if (cnt_inc >= {1'b0, eff_on}) begin
                     state_nxt = HIDE;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_inc[CNT_W-1:0];
                  end
               end
            end
            HIDE: begin
               if (restart) begin
                  state_nxt = SHOW;
                  cnt_nxt   = '0;
               end else if (tick) begin
                  if (cnt_inc >= {1'b0, eff_off}) begin
                     state_nxt = SHOW;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt_inc[CNT_W-1:0];
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Leaving a blink mode un-hides in the same cycle, before the FSM reaches IDLE.
   assign hide    = (state == HIDE) && blink_now;
   assign visible = !hide;

endmodule

// File: rtl/multi_digit_blink_ctrl.sv
// Gates an active-low N-digit anode bus so masked digits blink with an on/off cadence.
module multi_digit_blink_ctrl
   import blink_pkg::*;
#(
   parameter int   NUM_DIGITS = 4,
   parameter int   CNT_W      = 8,
   parameter logic ANODE_OFF  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic [NUM_DIGITS-1:0] anode_in,
   input  logic [NUM_DIGITS-1:0] blink_mask,
   input  logic [1:0]            mode,
   input  logic [CNT_W-1:0]      on_ticks,
   input  logic [CNT_W-1:0]      off_ticks,
   input  logic                  restart,
   output logic [NUM_DIGITS-1:0] anode_out,
   output logic                  visible
);

   logic                  hide;
   logic                  phase_visible;
   logic [NUM_DIGITS-1:0] anode_nxt;

   blink_phase_gen #(
      .CNT_W (CNT_W)
   ) u_phase (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .restart   (restart),
      .mode      (mode),
      .on_ticks  (on_ticks),
      .off_ticks (off_ticks),
      .hide      (hide),
      .visible   (phase_visible)
   );

   always_comb begin
      anode_nxt = anode_in;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (mode == BLANK) begin
            anode_nxt[i] = ANODE_OFF;
         end else if (hide && blink_mask[i]) begin
            anode_nxt[i] = ANODE_OFF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anode_out <= {NUM_DIGITS{ANODE_OFF}};
         visible   <= 1'b1;
      end else begin
         anode_out <= anode_nxt;
         visible   <= phase_visible;
      end
   end

endmodule

// File: tb/tb_multi_digit_blink_ctrl.sv
// Directed-vector bench for multi_digit_blink_ctrl with hand-computed expectations.
module tb_multi_digit_blink_ctrl;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic [3:0] anode_in;
   logic [3:0] blink_mask;
   logic [1:0] mode;
   logic [7:0] on_ticks;
   logic [7:0] off_ticks;
   logic       restart;
   logic [3:0] anode_out;
   logic       visible;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SHOW = 2'd1;
   localparam logic [1:0] ST_HIDE = 2'd2;

   multi_digit_blink_ctrl #(
      .NUM_DIGITS (4),
      .CNT_W      (8),
      .ANODE_OFF  (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .anode_in   (anode_in),
      .blink_mask (blink_mask),
      .mode       (mode),
      .on_ticks   (on_ticks),
      .off_ticks  (off_ticks),
      .restart    (restart),
      .anode_out  (anode_out),
      .visible    (visible)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Checking
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drivers: every drive and every sample happens 1 ns after a rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One tick strobe, then wait until anode_out/visible reflect the resulting state.
   task automatic do_tick();
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(1);
   endtask

   task automatic check_out(input string tag, input logic [3:0] exp_anode, input logic exp_vis);
      check({tag, "_anode"}, {28'd0, anode_out}, {28'd0, exp_anode});
      check({tag, "_vis"}, {31'd0, visible}, {31'd0, exp_vis});
   endtask

   task automatic check_fsm(input string tag, input logic [1:0] exp_state, input logic [7:0] exp_cnt);
      check({tag, "_state"}, {30'd0, dut.u_phase.state}, {30'd0, exp_state});
      check({tag, "_cnt"}, {24'd0, dut.u_phase.cnt}, {24'd0, exp_cnt});
   endtask

   // Stimulus
   initial begin
      rst_n      = 1'b0;
      tick       = 1'b0;
      restart    = 1'b0;
      anode_in   = 4'b0101;
      blink_mask = 4'b0000;
      mode       = 2'd0;
      on_ticks   = 8'd0;
      off_ticks  = 8'd0;

      // Reset
      step(3);
      check_out("rst", 4'b1111, 1'b1);
      check_fsm("rst", ST_IDLE, 8'd0);
      rst_n = 1'b1;
      step(2);
      check_out("pass_after_rst", 4'b0101, 1'b1);

      // Symmetric blink: 1010 with low two digits masked -> 1011 while hidden
      mode       = 2'd1;
      on_ticks   = 8'd2;
      blink_mask = 4'b0011;
      anode_in   = 4'b1010;
      step(1);
      check_fsm("sym_enter", ST_SHOW, 8'd0);
      step(1);
      check_out("sym_start", 4'b1010, 1'b1);
      do_tick(); check_out("sym_t1", 4'b1010, 1'b1); check_fsm("sym_t1", ST_SHOW, 8'd1); step(8);
      do_tick(); check_out("sym_t2", 4'b1011, 1'b0); step(8);
      do_tick(); check_out("sym_t3", 4'b1011, 1'b0); step(8);
      do_tick(); check_out("sym_t4", 4'b1010, 1'b1); step(8);
      do_tick(); check_out("sym_t5", 4'b1010, 1'b1); step(8);
      do_tick(); check_out("sym_t6", 4'b1011, 1'b0); step(8);
      do_tick(); check_out("sym_t7", 4'b1011, 1'b0); step(8);
      do_tick(); check_out("sym_t8", 4'b1010, 1'b1);
      check_fsm("sym_end", ST_SHOW, 8'd0);

      // Asymmetric blink: 3 visible ticks, 1 hidden tick, full mask
      mode       = 2'd2;
      on_ticks   = 8'd3;
      off_ticks  = 8'd1;
      blink_mask = 4'b1111;
      step(1);
      check_fsm("asym_switch", ST_SHOW, 8'd0);
      do_tick(); check_out("asym_t1", 4'b1010, 1'b1);
      do_tick(); check_out("asym_t2", 4'b1010, 1'b1);
      do_tick(); check_out("asym_t3", 4'b1111, 1'b0);
      do_tick(); check_out("asym_t4", 4'b1010, 1'b1);
      on_ticks = 8'd0;
      do_tick(); check_out("asym_on0_t1", 4'b1111, 1'b0);
      do_tick(); check_out("asym_on0_t2", 4'b1010, 1'b1);
      do_tick(); check_out("asym_on0_t3", 4'b1111, 1'b0);
      do_tick(); check_out("asym_on0_t4", 4'b1010, 1'b1);

      // Restart beats a phase-ending tick during SHOW
      on_ticks = 8'd3;
      do_tick();
      do_tick();
      check_fsm("rs_pre", ST_SHOW, 8'd2);
      tick    = 1'b1;
      restart = 1'b1;
      step(1);
      tick    = 1'b0;
      restart = 1'b0;
      check_fsm("rs_post", ST_SHOW, 8'd0);
      step(1);
      check_out("rs_post", 4'b1010, 1'b1);
      do_tick(); check_out("rs_t1", 4'b1010, 1'b1);
      do_tick(); check_out("rs_t2", 4'b1010, 1'b1);
      do_tick(); check_out("rs_t3", 4'b1111, 1'b0);
      check_fsm("rs_t3", ST_HIDE, 8'd0);

      // Mode exit from HIDE: PASS then BLANK
      anode_in = 4'b0110;
      mode     = 2'd0;
      step(1);
      check_out("exit_pass", 4'b0110, 1'b1);
      check_fsm("exit_pass", ST_IDLE, 8'd0);
      mode       = 2'd3;
      blink_mask = 4'b0000;
      step(1);
      check_out("exit_blank", 4'b1111, 1'b1);
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      check_fsm("idle_restart", ST_IDLE, 8'd0);

      // Mid-operation reset in HIDE with cnt = 1
      mode       = 2'd2;
      on_ticks   = 8'd3;
      off_ticks  = 8'd3;
      blink_mask = 4'b1111;
      anode_in   = 4'b0011;
      step(1);
      do_tick();
      do_tick();
      do_tick();
      do_tick();
      check_fsm("mid_pre", ST_HIDE, 8'd1);
      check_out("mid_pre", 4'b1111, 1'b0);
      anode_in   = 4'b0000;
      blink_mask = 4'b0000;
      #2;
      rst_n = 1'b0;
      #1;
      check_out("mid_rst", 4'b1111, 1'b1);
      check_fsm("mid_rst", ST_IDLE, 8'd0);
      mode = 2'd0;
      step(2);
      rst_n = 1'b1;
      step(1);
      check_fsm("mid_rel", ST_IDLE, 8'd0);
      check_out("mid_rel", 4'b0000, 1'b1);
      mode       = 2'd2;
      blink_mask = 4'b1111;
      step(1);
      check_fsm("mid_reenter", ST_SHOW, 8'd0);
      do_tick();
      check_fsm("mid_reenter_t1", ST_SHOW, 8'd1);
      check_out("mid_reenter_t1", 4'b0000, 1'b1);

      // Report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
